mmu_req_arbiter: RTL and testbench
==================================

Name: mmu_req_arbiter

Overview:
Shares the single MMU lookup path (cache controller plus memory map) between the instruction-fetch and data-access requesters of the multithreaded core. Accepts one outstanding request per side, grants the downstream port with round-robin fairness, and holds the opcode/address/thread stable until the MMU acknowledges. Returns data, miss and segfault status to the requester that owns the grant.

Parameters:
AW, 32, address width
DW, 32, data width
TW, 3, thread-id width (8 hardware threads)
TIMEOUT_CYC, 64, watchdog limit in cycles; used only with the optional feature

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
i_req  in  1  fetch request, level, held until i_done
i_addr  in  AW  fetch address
i_trd  in  TW  fetch thread id
i_done  out  1  one-cycle completion pulse to fetch
i_rd_data  out  DW  fetch read data, valid with i_done
i_miss  out  1  fetch miss status, valid with i_done
i_segfault  out  1  fetch segfault status, valid with i_done
d_req  in  1  data request, level, held until d_done
d_wr  in  1  1 = write, 0 = read; sampled at grant
d_addr  in  AW  data address
d_wr_data  in  DW  write data
d_trd  in  TW  data thread id
d_done  out  1  one-cycle completion pulse to data side
d_rd_data  out  DW  data-side read data
d_miss  out  1  data-side miss status
d_segfault  out  1  data-side segfault status
mem_op  out  2  MMU opcode: IDLE 2'b00, READ 2'b01, WRITE 2'b11
mem_addr  out  AW  MMU address
mem_wr_data  out  DW  MMU write data
mem_trd  out  TW  MMU thread id
mem_ack  in  1  one-cycle MMU completion
mem_rd_data  in  DW  MMU read data, valid with mem_ack
mem_miss  in  1  MMU miss, valid with mem_ack
mem_segfault  in  1  MMU segfault, valid with mem_ack

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; mem_op = IDLE; mem_addr, mem_wr_data and mem_trd = 0; every *_done, *_miss, *_segfault and *_rd_data = 0; round-robin pointer last_grant = D, so fetch wins the first tie.
- States: IDLE, BUSY_I, BUSY_D.
- IDLE: if only one side requests, grant that side. If both request, grant the side that is not last_grant. Registered grant: mem_op, mem_addr, mem_trd and mem_wr_data are loaded on the grant edge and are valid the next cycle.
  - Fetch grant: mem_op = READ; mem_wr_data = 0.
  - Data grant: mem_op = WRITE if d_wr, else READ.
  - Update last_grant on the grant.
- BUSY_x: all mem_* outputs hold stable, with no requester input sampled.
  - On mem_ack: latch rd_data, miss and segfault into the owner's outputs; pulse owner's *_done for exactly one cycle (cycle after mem_ack); mem_op -> IDLE; return to IDLE.
  - Write completions: d_rd_data = 0.
- Minimum latency: request seen in IDLE at cycle 0; mem_op valid at cycle 1. mem_ack at cycle N gives *_done at N+1. Next grant is no earlier than N+1.
- Status outputs (*_rd_data/*_miss/*_segfault): hold their last values between pulses; qualify them only with *_done.
- mem_ack while IDLE: ignore.
- Requester deasserting its req mid-transaction: ignore; the transaction completes and done still pulses.
- A requester may reassert in the cycle after its done. Fairness guarantees no side waits more than one foreign transaction.
- miss/segfault: pass through unchanged, with no retry inside this block. Refill sequencing belongs to the cache controller, and fault handling belongs to the core.

Optional Feature:
MMU_ARB_TIMEOUT_EN:
- Defined: a counter clears on grant and increments each BUSY cycle. When it reaches TIMEOUT_CYC without mem_ack:
  - force completion: owner's done = 1, segfault = 1, miss = 0, rd_data = 0;
  - mem_op = IDLE; return to IDLE;
  - set sticky output port arb_timeout (1 bit, cleared only by reset).
  - A mem_ack arriving after a timeout is ignored.
- Undefined: no counter and no arb_timeout port; BUSY waits indefinitely.

Decomposition:
- Shared package mmu_pkg:
  - mem_op_t enum (IDLE = 2'b00, READ = 2'b01, WRITE = 2'b11)
  - arb_state_t enum (IDLE, BUSY_I, BUSY_D)
  - AW/DW/TW default constants
  - requester-id type (REQ_I, REQ_D)
- One natural sub-module: mmu_rr_pick, a two-input round-robin selector taking req_i, req_d and last_grant and returning grant_i/grant_d.

Test Plan:
- Fetch-only read: i_req=1, i_addr=0x0000_1000, i_trd=3; mem_ack after 2 cycles with mem_rd_data=0xDEAD_BEEF -> mem_op=READ, mem_trd=3 while busy; i_done one cycle with i_rd_data=0xDEAD_BEEF; d_done stays 0.
- Data write: d_req=1, d_wr=1, d_addr=0x2004, d_wr_data=0x55AA_55AA -> mem_op=WRITE, mem_wr_data=0x55AA_55AA stable until ack; d_done pulse, d_rd_data=0.
- Contention: i_req and d_req both held for 4 transactions, each acked after 1 cycle -> grant order I, D, I, D; neither done ever pulses twice in a row.
- Fault passthrough: data read acked with mem_segfault=1, mem_miss=0 -> d_segfault=1 with d_done; a following fetch ack with mem_miss=1 -> i_miss=1, i_segfault=0.
- Reset mid-transaction: assert rst_n=0 while BUSY_D -> same-cycle mem_op=IDLE and all done/status=0. After release, a tie grants fetch first.
- With MMU_ARB_TIMEOUT_EN and TIMEOUT_CYC=8: grant fetch with no ack -> after 8 busy cycles i_done=1, i_segfault=1, arb_timeout=1. A late mem_ack produces no extra done.

Source files
------------

// File: rtl/mmu_req_arbiter_pkg.sv
// Shared types for the MMU request arbiter: opcodes, FSM states, requester ids.
package mmu_pkg;

   localparam int unsigned MMU_AW = 32;
   localparam int unsigned MMU_DW = 32;
   localparam int unsigned MMU_TW = 3;

   typedef enum logic [1:0] {
      OP_IDLE  = 2'b00,
      OP_READ  = 2'b01,
      OP_WRITE = 2'b11
   } mem_op_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY_I,
      ST_BUSY_D
   } arb_state_t;

   typedef enum logic {
      REQ_I = 1'b0,
      REQ_D = 1'b1
   } req_id_t;

endpackage

// File: rtl/mmu_rr_pick.sv
// Two-input round-robin selector: a tie goes to the side that was not granted last.
module mmu_rr_pick
   import mmu_pkg::*;
(
   input  logic req_i,
   input  logic req_d,
   input  logic last_grant,
   output logic grant_i,
   output logic grant_d
);

   assign grant_i = req_i & (~req_d | (last_grant == REQ_D));
   assign grant_d = req_d & ~grant_i;

endmodule

// File: rtl/mmu_req_arbiter.sv
// Arbitrates fetch and data requesters onto the single MMU lookup port.
// Optional watchdog with sticky arb_timeout port: define MMU_ARB_TIMEOUT_EN.
module mmu_req_arbiter
   import mmu_pkg::*;
#(
   parameter int unsigned AW          = MMU_AW,
   parameter int unsigned DW          = MMU_DW,
   parameter int unsigned TW          = MMU_TW,
   parameter int unsigned TIMEOUT_CYC = 64
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   input  logic [TW-1:0] i_trd,
   output logic          i_done,
   output logic [DW-1:0] i_rd_data,
   output logic          i_miss,
   output logic          i_segfault,
   input  logic          d_req,
   input  logic          d_wr,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wr_data,
   input  logic [TW-1:0] d_trd,
   output logic          d_done,
   output logic [DW-1:0] d_rd_data,
   output logic          d_miss,
   output logic          d_segfault,
   output logic [1:0]    mem_op,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wr_data,
   output logic [TW-1:0] mem_trd,
   input  logic          mem_ack,
   input  logic [DW-1:0] mem_rd_data,
   input  logic          mem_miss,
   input  logic          mem_segfault
`ifdef MMU_ARB_TIMEOUT_EN
   ,
   output logic          arb_timeout
`endif
);

   if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYC must be at least 1");
   end

   arb_state_t state_q, state_d;
   mem_op_t    op_q;
   req_id_t    last_q;
   logic       pick_i, pick_d;
   logic       grant_i, grant_d;
   logic       finish, forced;

   // A requester still holding req during its own done pulse is not re-granted.
   mmu_rr_pick u_pick (
      .req_i      (i_req & ~i_done),
      .req_d      (d_req & ~d_done),
      .last_grant (last_q),
      .grant_i    (pick_i),
      .grant_d    (pick_d)
   );

   assign mem_op = op_q;

`ifdef MMU_ARB_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
   logic [CW-1:0] tmo_cnt;
   logic          tmo_hit;

   assign tmo_hit = (tmo_cnt == CW'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt     <= '0;
         arb_timeout <= 1'b0;
      end else begin
         if (grant_i || grant_d)
            tmo_cnt <= '0;
         else if (state_q != ST_IDLE)
            tmo_cnt <= tmo_cnt + 1'b1;
         if (forced)
            arb_timeout <= 1'b1;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      grant_i = 1'b0;
      grant_d = 1'b0;
      finish  = 1'b0;
      forced  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pick_i) begin
               grant_i = 1'b1;
               state_d = ST_BUSY_I;
            end else if (pick_d) begin
               grant_d = 1'b1;
               state_d = ST_BUSY_D;
            end
         end
         ST_BUSY_I, ST_BUSY_D: begin
            if (mem_ack)
               finish = 1'b1;
`ifdef MMU_ARB_TIMEOUT_EN
            else if (tmo_hit) begin
               finish = 1'b1;
               forced = 1'b1;
            end
`endif
            if (finish)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q        <= OP_IDLE;
         last_q      <= REQ_D;
         mem_addr    <= '0;
         mem_wr_data <= '0;
         mem_trd     <= '0;
         i_done      <= 1'b0;
         i_rd_data   <= '0;
         i_miss      <= 1'b0;
         i_segfault  <= 1'b0;
         d_done      <= 1'b0;
         d_rd_data   <= '0;
         d_miss      <= 1'b0;
         d_segfault  <= 1'b0;
      end else begin
         i_done <= 1'b0;
         d_done <= 1'b0;
         if (grant_i) begin
            op_q        <= OP_READ;
            mem_addr    <= i_addr;
            mem_trd     <= i_trd;
            mem_wr_data <= '0;
            last_q      <= REQ_I;
         end else if (grant_d) begin
            op_q        <= d_wr ? OP_WRITE : OP_READ;
            mem_addr    <= d_addr;
            mem_trd     <= d_trd;
            mem_wr_data <= d_wr_data;
            last_q      <= REQ_D;
         end
         if (finish) begin
            op_q <= OP_IDLE;
            if (state_q == ST_BUSY_I) begin
               i_done     <= 1'b1;
               i_rd_data  <= forced ? '0 : mem_rd_data;
               i_miss     <= forced ? 1'b0 : mem_miss;
               i_segfault <= forced | mem_segfault;
            end else begin
               d_done     <= 1'b1;
               d_rd_data  <= (forced || op_q == OP_WRITE) ? '0 : mem_rd_data;
               d_miss     <= forced ? 1'b0 : mem_miss;
               d_segfault <= forced | mem_segfault;
            end
         end
      end
   end

endmodule

// File: tb/tb_mmu_req_arbiter.sv
// Directed and randomized checks of mmu_req_arbiter against a transaction-level model.
module tb_mmu_req_arbiter;

   localparam int unsigned TMO = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_req = 1'b0, d_req = 1'b0, d_wr = 1'b0;
   logic [31:0] i_addr = '0, d_addr = '0, d_wr_data = '0;
   logic [2:0]  i_trd = '0, d_trd = '0;
   logic        mem_ack = 1'b0, mem_miss = 1'b0, mem_segfault = 1'b0;
   logic [31:0] mem_rd_data = '0;
   logic        i_done, i_miss, i_segfault, d_done, d_miss, d_segfault;
   logic [31:0] i_rd_data, d_rd_data, mem_addr, mem_wr_data;
   logic [1:0]  mem_op;
   logic [2:0]  mem_trd;
`ifdef MMU_ARB_TIMEOUT_EN
   logic        arb_timeout;
`endif

   int unsigned tests = 0;
   int unsigned fails = 0;

   // model: owner/last 1 = fetch, 2 = data, owner 0 = idle
   int          m_owner, m_last, m_bcnt;
   logic [1:0]  m_op;
   logic [31:0] m_addr, m_wd, m_i_rd, m_d_rd;
   logic [2:0]  m_trd;
   logic        m_i_done, m_d_done, m_i_miss, m_i_seg, m_d_miss, m_d_seg, m_tmo;
   int unsigned i_act, d_act;

   always #5 clk = ~clk;

   mmu_req_arbiter #(.AW(32), .DW(32), .TW(3), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_trd(i_trd), .i_done(i_done),
      .i_rd_data(i_rd_data), .i_miss(i_miss), .i_segfault(i_segfault),
      .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wr_data(d_wr_data), .d_trd(d_trd),
      .d_done(d_done), .d_rd_data(d_rd_data), .d_miss(d_miss), .d_segfault(d_segfault),
      .mem_op(mem_op), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_trd(mem_trd),
      .mem_ack(mem_ack), .mem_rd_data(mem_rd_data), .mem_miss(mem_miss),
      .mem_segfault(mem_segfault)
`ifdef MMU_ARB_TIMEOUT_EN
      , .arb_timeout(arb_timeout)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_owner = 0; m_last = 2; m_bcnt = 0; m_op = 2'b00;
      m_addr = '0; m_wd = '0; m_trd = '0; m_i_rd = '0; m_d_rd = '0;
      m_i_done = 0; m_d_done = 0; m_i_miss = 0; m_i_seg = 0;
      m_d_miss = 0; m_d_seg = 0; m_tmo = 0;
   endtask

   task automatic check_all();
      chk("mem_op", 32'(mem_op), 32'(m_op));
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wr_data", mem_wr_data, m_wd);
      chk("mem_trd", 32'(mem_trd), 32'(m_trd));
      chk("i_done", 32'(i_done), 32'(m_i_done));
      chk("d_done", 32'(d_done), 32'(m_d_done));
      chk("i_rd_data", i_rd_data, m_i_rd);
      chk("i_miss", 32'(i_miss), 32'(m_i_miss));
      chk("i_segfault", 32'(i_segfault), 32'(m_i_seg));
      chk("d_rd_data", d_rd_data, m_d_rd);
      chk("d_miss", 32'(d_miss), 32'(m_d_miss));
      chk("d_segfault", 32'(d_segfault), 32'(m_d_seg));
`ifdef MMU_ARB_TIMEOUT_EN
      chk("arb_timeout", 32'(arb_timeout), 32'(m_tmo));
`endif
   endtask

   // Predict the effect of the coming clock edge from the applied inputs, clock, compare.
   task automatic step();
      logic gi, gd, frc;
      frc = 1'b0;
      m_i_done = 0;
      m_d_done = 0;
      if (m_owner == 0) begin
         gi = i_req && (!d_req || m_last == 2);
         gd = d_req && !gi;
         if (gi) begin
            m_owner = 1; m_last = 1; m_op = 2'b01; m_addr = i_addr;
            m_trd = i_trd; m_wd = '0; m_bcnt = 0;
         end else if (gd) begin
            m_owner = 2; m_last = 2; m_op = d_wr ? 2'b11 : 2'b01; m_addr = d_addr;
            m_trd = d_trd; m_wd = d_wr_data; m_bcnt = 0;
         end
      end else begin
`ifdef MMU_ARB_TIMEOUT_EN
         frc = !mem_ack && (m_bcnt + 1 == int'(TMO));
`endif
         if (mem_ack || frc) begin
            if (m_owner == 1) begin
               m_i_done = 1;
               m_i_rd   = frc ? '0 : mem_rd_data;
               m_i_miss = frc ? 1'b0 : mem_miss;
               m_i_seg  = frc | mem_segfault;
            end else begin
               m_d_done = 1;
               m_d_rd   = (frc || m_op == 2'b11) ? '0 : mem_rd_data;
               m_d_miss = frc ? 1'b0 : mem_miss;
               m_d_seg  = frc | mem_segfault;
            end
            if (frc) m_tmo = 1;
            m_op = 2'b00;
            m_owner = 0;
         end else begin
            m_bcnt++;
         end
      end
      @(posedge clk);
      #1;
      check_all();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      i_act = 0;
      d_act = 0;
      #12;
      check_all();
      @(negedge clk);
      rst_n = 1'b1;

      // fetch-only read
      i_req = 1; i_addr = 32'h0000_1000; i_trd = 3;
      step();
      chk("fo_op", 32'(mem_op), 32'd1);
      chk("fo_trd", 32'(mem_trd), 32'd3);
      i_addr = 32'hAAAA_0000;
      step();
      chk("fo_addr_hold", mem_addr, 32'h0000_1000);
      mem_ack = 1; mem_rd_data = 32'hDEAD_BEEF;
      step();
      mem_ack = 0;
      chk("fo_done", 32'(i_done), 32'd1);
      chk("fo_data", i_rd_data, 32'hDEAD_BEEF);
      chk("fo_ddone", 32'(d_done), 32'd0);
      i_req = 0;
      step();
      chk("fo_pulse", 32'(i_done), 32'd0);

      // data write
      d_req = 1; d_wr = 1; d_addr = 32'h2004; d_wr_data = 32'h55AA_55AA; d_trd = 1;
      step();
      chk("dw_op", 32'(mem_op), 32'd3);
      d_wr_data = 32'h1234_5678; d_wr = 0;
      step();
      chk("dw_wd_hold", mem_wr_data, 32'h55AA_55AA);
      mem_ack = 1; mem_rd_data = 32'hFFFF_0000;
      step();
      mem_ack = 0;
      chk("dw_done", 32'(d_done), 32'd1);
      chk("dw_rd_zero", d_rd_data, 32'd0);
      d_req = 0;
      step();

      // contention: alternating grants
      i_req = 1; i_addr = 32'h100; i_trd = 1;
      d_req = 1; d_addr = 32'h200; d_trd = 6; d_wr = 0;
      for (int unsigned k = 0; k < 4; k++) begin
         step();
         chk("ct_order", 32'(mem_trd), (k % 2 == 0) ? 32'd1 : 32'd6);
         mem_ack = 1; mem_rd_data = $urandom;
         step();
         mem_ack = 0;
         chk("ct_idone", 32'(i_done), (k % 2 == 0) ? 32'd1 : 32'd0);
         chk("ct_ddone", 32'(d_done), (k % 2 == 0) ? 32'd0 : 32'd1);
      end
      i_req = 0; d_req = 0;
      step();

      // fault passthrough
      d_req = 1; d_wr = 0; d_addr = 32'h300;
      step();
      mem_ack = 1; mem_segfault = 1; mem_miss = 0;
      step();
      chk("f_dseg", 32'(d_segfault), 32'd1);
      chk("f_ddone", 32'(d_done), 32'd1);
      d_req = 0; mem_ack = 0; mem_segfault = 0;
      i_req = 1; i_addr = 32'h400;
      step();
      mem_ack = 1; mem_miss = 1;
      step();
      chk("f_imiss", 32'(i_miss), 32'd1);
      chk("f_iseg", 32'(i_segfault), 32'd0);
      i_req = 0; mem_ack = 0; mem_miss = 0;
      step();

      // reset while BUSY_D
      d_req = 1; d_wr = 1; d_addr = 32'h500; d_trd = 5;
      step();
      chk("rm_busy", 32'(mem_op), 32'd3);
      rst_n = 0;
      #1;
      model_reset();
      chk("rm_op", 32'(mem_op), 32'd0);
      chk("rm_imiss", 32'(i_miss), 32'd0);
      chk("rm_dseg", 32'(d_segfault), 32'd0);
      check_all();
      @(negedge clk);
      rst_n = 1;
      i_req = 1; i_trd = 2; d_wr = 0;
      step();
      chk("rm_tie", 32'(mem_trd), 32'd2);
      mem_ack = 1;
      step();
      i_req = 0; mem_ack = 0;
      step();
      mem_ack = 1;
      step();
      d_req = 0; mem_ack = 0;
      step();

      // randomized traffic
      for (int unsigned c = 0; c < 400; c++) begin
         if (m_i_done) begin
            i_req = 0; i_act = 0;
         end else if (i_act == 0) begin
            if ($urandom_range(0, 2) == 0) begin
               i_req = 1; i_act = 1; i_addr = $urandom; i_trd = 3'($urandom);
            end
         end else if (m_owner == 1) begin
            i_addr = $urandom;
            if ($urandom_range(0, 7) == 0) i_req = 0;
         end
         if (m_d_done) begin
            d_req = 0; d_act = 0;
         end else if (d_act == 0) begin
            if ($urandom_range(0, 2) == 0) begin
               d_req = 1; d_act = 1; d_addr = $urandom; d_trd = 3'($urandom);
               d_wr = 1'($urandom); d_wr_data = $urandom;
            end
         end else if (m_owner == 2) begin
            d_addr = $urandom; d_wr_data = $urandom; d_wr = 1'($urandom);
            if ($urandom_range(0, 7) == 0) d_req = 0;
         end
         mem_ack      = ($urandom_range(0, 2) == 0);
         mem_rd_data  = $urandom;
         mem_miss     = 1'($urandom);
         mem_segfault = 1'($urandom);
         step();
      end

      i_req = 0; d_req = 0; mem_ack = 1;
      repeat (3) step();
      mem_ack = 0;
      chk("drain_idle", 32'(mem_op), 32'd0);

`ifdef MMU_ARB_TIMEOUT_EN
      // watchdog forces completion after TMO busy cycles
      i_req = 1; i_trd = 4; i_addr = 32'h600;
      step();
      repeat (TMO - 1) step();
      chk("to_early", 32'(i_done), 32'd0);
      step();
      chk("to_done", 32'(i_done), 32'd1);
      chk("to_seg", 32'(i_segfault), 32'd1);
      chk("to_flag", 32'(arb_timeout), 32'd1);
      i_req = 0; mem_ack = 1;
      step();
      chk("to_late", 32'(i_done), 32'd0);
      mem_ack = 0;
      step();
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
